// File: rtl/intr_ctrl_pkg.sv
// ============================================================================
// intr_ctrl_pkg : shared encodings and helpers for the interrupt controller
// Revision      : 1.0
// ============================================================================
`default_nettype none

package intr_ctrl_pkg;

  localparam int N_SRC = 4;

  localparam logic [1:0] SRC_EXT1  = 2'd0;
  localparam logic [1:0] SRC_EXT2  = 2'd1;
  localparam logic [1:0] SRC_EXT3  = 2'd2;
  localparam logic [1:0] SRC_TIMER = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    SERVICE  = 2'd2
  } state_e;

  // Lowest set index wins; result is don't-care when req is zero.
  function automatic logic [1:0] prio_pick(input logic [N_SRC-1:0] req);
    logic [1:0] idx;
    idx = SRC_TIMER;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [N_SRC-1:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/intr_ctrl_if.sv
// ============================================================================
// intr_ctrl_if : request, software-register and control-unit signals
// Revision     : 1.0
// ============================================================================
`default_nettype none

interface intr_ctrl_if #(
  parameter int TIMER_W = 16
);
  logic [2:0]         irq_in;
  logic               mask_we;
  logic [3:0]         mask_in;
  logic               tmr_we;
  logic [TIMER_W-1:0] tmr_reload;
  logic               int_ack;
  logic               reti;
  logic               ie1;
  logic               ie2;
  logic               ie3;
  logic               ie4;
  logic [3:0]         pending;
  logic [3:0]         in_service;
  logic               busy;

  modport master (
    output irq_in, mask_we, mask_in, tmr_we, tmr_reload, int_ack, reti,
    input  ie1, ie2, ie3, ie4, pending, in_service, busy
  );

  modport slave (
    input  irq_in, mask_we, mask_in, tmr_we, tmr_reload, int_ack, reti,
    output ie1, ie2, ie3, ie4, pending, in_service, busy
  );
endinterface

`default_nettype wire

// File: rtl/intr_ctrl_timer.sv
// ============================================================================
// intr_timer : periodic reload down-counter raising a terminal-count pulse
// Revision   : 1.0
// ============================================================================
`default_nettype none

module intr_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tmr_we,
  input  logic [TIMER_W-1:0] tmr_reload,
  output logic               tc
);

  logic [TIMER_W-1:0] reload_q, reload_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    reload_d = reload_q;
    cnt_d    = cnt_q;
    tc       = 1'b0;
    // A software load during terminal count suppresses that cycle's pulse.
    if (tmr_we) begin
      reload_d = tmr_reload;
      cnt_d    = tmr_reload;
    end else if (reload_q != '0) begin
      if (cnt_q == TIMER_W'(1)) begin
        cnt_d = reload_q;
        tc    = 1'b1;
      end else if (cnt_q == '0) begin
        cnt_d = reload_q;
      end else begin
        cnt_d = cnt_q - TIMER_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload_q <= '0;
      cnt_q    <= '0;
    end else begin
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/intr_ctrl.sv
// ============================================================================
// intr_ctrl : prioritised, masked, one-at-a-time interrupt dispatcher
// Revision  : 1.0
// ============================================================================
`default_nettype none

module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int TIMER_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  intr_ctrl_if.slave  bus
);

  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic [2:0]       edge_q, edge_d;
  logic [2:0]       rise;
  logic             tmr_tc;
  logic [N_SRC-1:0] set_vec;
  logic [N_SRC-1:0] clr_vec;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] ie_vec;

  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] in_service_q, in_service_d;
  logic [3:0]       mask_q, mask_d;
  logic [1:0]       winner_q, winner_d;
  state_e           state_q, state_d;

  intr_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .tmr_we     (bus.tmr_we),
    .tmr_reload (bus.tmr_reload),
    .tc         (tmr_tc)
  );

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.irq_in};
    edge_d = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~edge_q;

    set_vec            = '0;
    set_vec[SRC_EXT1]  = rise[0];
    set_vec[SRC_EXT2]  = rise[1];
    set_vec[SRC_EXT3]  = rise[2];
    set_vec[SRC_TIMER] = tmr_tc;
  end

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    in_service_d = in_service_q;
    mask_d       = bus.mask_we ? bus.mask_in : mask_q;
    clr_vec      = '0;
    eligible     = pending_q & mask_q;

    case (state_q)
      IDLE: begin
        if (bus.int_ack && (eligible != '0)) begin
          winner_d = prio_pick(eligible);
          state_d  = DISPATCH;
        end
      end
      DISPATCH: begin
        clr_vec      = onehot(winner_q);
        in_service_d = onehot(winner_q);
        state_d      = SERVICE;
      end
      SERVICE: begin
        if (bus.reti) begin
          in_service_d = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh edge on the source being cleared keeps it pending.
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q       <= '0;
      edge_q       <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= '0;
      winner_q     <= '0;
      state_q      <= IDLE;
    end else begin
      sync_q       <= sync_d;
      edge_q       <= edge_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      mask_q       <= mask_d;
      winner_q     <= winner_d;
      state_q      <= state_d;
    end
  end

  assign ie_vec         = (state_q == DISPATCH) ? onehot(winner_q) : '0;
  assign bus.ie1        = ie_vec[0];
  assign bus.ie2        = ie_vec[1];
  assign bus.ie3        = ie_vec[2];
  assign bus.ie4        = ie_vec[3];
  assign bus.pending    = pending_q;
  assign bus.in_service = in_service_q;
  assign bus.busy       = (state_q == DISPATCH) || (state_q == SERVICE);

endmodule

`default_nettype wire

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller that sequences the datapath's four interrupt vector inputs (ie1..ie4).
- Captures three external request lines and one internal periodic timer source.
- Applies a software-written enable mask and a fixed priority, and dispatches one interrupt at a time.
- Each dispatch is a single-cycle one-hot pulse on ie1..ie4, which drives the PC vector mux select and the stack push.
- Sits beside the control unit: the control unit grants dispatch at instruction boundaries and signals return-from-interrupt.

Parameters:
- TIMER_W, 16, width of timer reload value and down-counter.
- SYNC_STAGES, 2, flip-flop stages on each external request line (minimum 2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state.
- irq_in  in  3  external requests for sources 1..3 (bit0 = source 1); asynchronous, rising-edge sensitive.
- mask_we  in  1  mask write strobe.
- mask_in  in  4  new enable mask; bit k enables source k+1.
- tmr_we  in  1  timer reload write strobe.
- tmr_reload  in  TIMER_W  timer period in cycles; 0 disables the timer.
- int_ack  in  1  control unit is at an instruction boundary and can accept a vector.
- reti  in  1  single-cycle return-from-interrupt strobe.
- ie1, ie2, ie3, ie4  out  1 each  one-cycle dispatch pulses, one-hot; source 4 is the timer.
- pending  out  4  latched requests not yet dispatched.
- in_service  out  4  one-hot source currently being serviced.
- busy  out  1  high while state is DISPATCH or SERVICE.

Behaviour:
- Reset values (async on reset=0):
  - pending=0, in_service=0, mask=0, timer reload=0, counter=0, sync/edge flops=0.
  - state=IDLE; ie1..ie4=0; busy=0.
- Request capture:
  - Each irq_in bit passes SYNC_STAGES flops, then an edge register.
  - A synced 0->1 transition sets pending[k].
  - Latency from irq_in rise to pending visible: SYNC_STAGES+1 cycles.
  - Level-high holding does not re-trigger.
- Timer:
  - tmr_we loads reload and counter from tmr_reload.
  - With reload!=0, counter decrements every cycle.
  - When counter==1, the next edge sets counter=reload and sets pending[3].
  - Period = reload cycles; reload=1 sets pending every cycle.
  - tmr_we during a terminal count: the load wins and no pending is set that cycle.
- Mask:
  - mask_we updates the mask at the clock edge.
  - The dispatch decision in the same cycle uses the old mask.
  - Masked requests stay pending.
- Priority: lowest index wins (source 1 highest), matching the datapath's 4:2 encoder.
- FSM:
  - IDLE: if int_ack and (pending & mask)!=0, latch the winner and go to DISPATCH. Otherwise stay. reti is ignored.
  - DISPATCH (exactly 1 cycle):
    - ie(winner)=1, all other ie=0.
    - pending[winner] cleared, in_service[winner] set.
    - Next state SERVICE.
  - SERVICE:
    - No nesting; new requests only accumulate in pending.
    - On reti: clear in_service and go to IDLE.
    - The earliest re-dispatch is 1 cycle after returning to IDLE.
- Latency: eligible request + int_ack in cycle n gives an ie pulse in cycle n+1.
- Outputs: ie* are decoded only from state and winner registers, so they are glitch-free.
- Simultaneous events:
  - A new edge on the source being cleared in DISPATCH wins: pending stays set.
  - int_ack low in IDLE defers dispatch indefinitely.
- Reset mid-DISPATCH or mid-SERVICE: immediate IDLE with all state cleared; the ie pulse is truncated.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, DISPATCH=2'd1, SERVICE=2'd2;
  - source index constants SRC_EXT1..SRC_TIMER (0..3);
  - N_SRC=4.
- One natural sub-module: intr_timer (reload register, down-counter, terminal-count pulse).
- Synchronizer, edge detect and FSM stay in intr_ctrl.

Test Plan:
- Reset values:
  - Stimulus: assert reset=0 mid-SERVICE with in_service=0001.
  - Response: all outputs 0 asynchronously; after release, busy=0 and mask=0.
- External request:
  - Stimulus: mask=1111, int_ack=1, raise irq_in[1].
  - Response: pending=0010 after 3 cycles; ie2 high exactly 1 cycle later; in_service=0010; busy=1 until reti.
- Priority:
  - Stimulus: pending sources 2 and 3 set together, mask=1111.
  - Response: ie2 first. After reti, ie3 follows 2 cycles later.
- Masking:
  - Stimulus: mask=1011 with source 3 pending.
  - Response: no dispatch, pending=0100 held. Writing mask=1111 gives ie3 on the next cycle.
- Timer:
  - Stimulus: tmr_reload=5, mask=1000, int_ack=1.
  - Response: ie4 pulses once per reti cycle. With int_ack=0 held, pending[3] is set 5 cycles after the load and stays set. tmr_reload=0 gives no pulses.
- No nesting:
  - Stimulus: in SERVICE for source 4, raise irq_in[0].
  - Response: pending=0001, no ie1 until after reti.
